// File: rtl/rtc_pkg.sv
// Shared constants for the PicoBlaze RTC output port:
// port map, command bits, bus FSM encoding and pad bundle.
package rtc_pkg;

  localparam logic [7:0] PORT_RTC_ADDR  = 8'h10;
  localparam logic [7:0] PORT_RTC_WDATA = 8'h11;
  localparam logic [7:0] PORT_RTC_CMD   = 8'h12;
  localparam logic [7:0] PORT_FMT       = 8'h13;

  localparam int CMD_WRITE_BIT = 0;
  localparam int CMD_READ_BIT  = 1;

  localparam int TIMER_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_AHOLD = 3'd2;
  localparam state_t ST_WSTB  = 3'd3;
  localparam state_t ST_RSTB  = 3'd4;
  localparam state_t ST_DHOLD = 3'd5;

  typedef struct packed {
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
  } pads_t;

  localparam pads_t PADS_IDLE = '{
    ad_out: 8'h00,
    ad_oe:  1'b0,
    cs_n:   1'b1,
    ale:    1'b0,
    rd_n:   1'b1,
    wr_n:   1'b1
  };

  // Timer counts down to zero, so a state of n cycles loads n-1.
  function automatic logic [TIMER_W-1:0] load_val(input int n);
    return TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/picoblaze_rtc_out_port_bus_fsm.sv
// RTC multiplexed bus sequencer: one shared down-counter,
// registered pads, read capture and done/busy status.
module rtc_bus_fsm
  import rtc_pkg::*;
#(
  parameter int T_SETUP = 4,
  parameter int T_HOLD  = 2,
  parameter int T_PULSE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       start_wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] rtc_ad_in,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  output logic       rtc_cs_n,
  output logic       rtc_ale,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 wr_op_q, wr_op_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  pads_t                pads_q, pads_d;
  logic                 tz;

  assign tz = (timer_q == '0);

  // State, timer, status and pad registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      wr_op_q   <= 1'b0;
      rd_data_q <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      pads_q    <= PADS_IDLE;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wr_op_q   <= wr_op_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      pads_q    <= pads_d;
    end
  end

  // Next state: each timed state exits when the timer hits zero
  always_comb begin
    state_d   = state_q;
    timer_d   = tz ? timer_q : timer_q - 1'b1;
    wr_op_d   = wr_op_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          timer_d = load_val(T_SETUP);
          wr_op_d = start_wr;
        end
      end
      ST_ADDR: begin
        if (tz) begin
          state_d = ST_AHOLD;
          timer_d = load_val(T_HOLD);
        end
      end
      ST_AHOLD: begin
        if (tz) begin
          state_d = wr_op_q ? ST_WSTB : ST_RSTB;
          timer_d = load_val(T_PULSE);
        end
      end
      ST_WSTB: begin
        if (tz) begin
          state_d = ST_DHOLD;
          timer_d = load_val(T_HOLD);
        end
      end
      ST_RSTB: begin
        if (tz) begin
          state_d   = ST_DHOLD;
          timer_d   = load_val(T_HOLD);
          rd_data_d = rtc_ad_in;
        end
      end
      ST_DHOLD: begin
        if (tz) begin
          state_d = ST_IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Pad and busy values for the state being entered
  always_comb begin
    pads_d = PADS_IDLE;
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_IDLE: ;
      ST_ADDR: begin
        pads_d.cs_n   = 1'b0;
        pads_d.ale    = 1'b1;
        pads_d.ad_oe  = 1'b1;
        pads_d.ad_out = addr;
      end
      ST_AHOLD: begin
        pads_d.cs_n   = 1'b0;
        pads_d.ad_oe  = 1'b1;
        pads_d.ad_out = addr;
      end
      ST_WSTB: begin
        pads_d.cs_n   = 1'b0;
        pads_d.wr_n   = 1'b0;
        pads_d.ad_oe  = 1'b1;
        pads_d.ad_out = wdata;
      end
      ST_RSTB: begin
        pads_d.cs_n = 1'b0;
        pads_d.rd_n = 1'b0;
      end
      ST_DHOLD: begin
        pads_d.cs_n   = 1'b0;
        pads_d.ad_oe  = wr_op_d;
        pads_d.ad_out = wr_op_d ? wdata : 8'h00;
      end
      default: ;
    endcase
  end

  assign rtc_ad_out = pads_q.ad_out;
  assign rtc_ad_oe  = pads_q.ad_oe;
  assign rtc_cs_n   = pads_q.cs_n;
  assign rtc_ale    = pads_q.ale;
  assign rtc_rd_n   = pads_q.rd_n;
  assign rtc_wr_n   = pads_q.wr_n;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: rtl/picoblaze_rtc_out_port.sv
// PicoBlaze OUTPUT-port decode for the RTC: control registers
// and command launch into the bus sequencer.
module picoblaze_rtc_out_port
  import rtc_pkg::*;
#(
  parameter int T_SETUP = 4,
  parameter int T_HOLD  = 2,
  parameter int T_PULSE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_strobe,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in,
  output logic       rtc_cs_n,
  output logic       rtc_ale,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       fmt_12h
);

  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       fmt_q, fmt_d;
  logic       start, start_wr;
  logic       sel_addr, sel_wdata, sel_cmd, sel_fmt;

  assign sel_addr  = write_strobe && (port_id == PORT_RTC_ADDR);
  assign sel_wdata = write_strobe && (port_id == PORT_RTC_WDATA);
  assign sel_cmd   = write_strobe && (port_id == PORT_RTC_CMD);
  assign sel_fmt   = write_strobe && (port_id == PORT_FMT);

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      fmt_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fmt_q   <= fmt_d;
    end
  end

  // Port decode; bus registers are frozen while a cycle runs
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fmt_d    = fmt_q;
    start    = 1'b0;
    start_wr = 1'b0;
    unique case (1'b1)
      sel_addr: begin
        if (!busy) addr_d = out_port;
      end
      sel_wdata: begin
        if (!busy) wdata_d = out_port;
      end
      sel_cmd: begin
        start    = !busy && (out_port[CMD_WRITE_BIT]
                          || out_port[CMD_READ_BIT]);
        start_wr = out_port[CMD_WRITE_BIT];
      end
      sel_fmt: fmt_d = out_port[0];
      default: ;
    endcase
  end

  rtc_bus_fsm #(
    .T_SETUP (T_SETUP),
    .T_HOLD  (T_HOLD),
    .T_PULSE (T_PULSE)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_wr   (start_wr),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .rtc_ad_in  (rtc_ad_in),
    .rtc_ad_out (rtc_ad_out),
    .rtc_ad_oe  (rtc_ad_oe),
    .rtc_cs_n   (rtc_cs_n),
    .rtc_ale    (rtc_ale),
    .rtc_rd_n   (rtc_rd_n),
    .rtc_wr_n   (rtc_wr_n),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done)
  );

  assign fmt_12h = fmt_q;

endmodule

// File: tb/tb_picoblaze_rtc_out_port.sv
// Scoreboard bench for picoblaze_rtc_out_port: stimulus pushes
// expected bus cycles, a negedge monitor checks each on done.
module tb_picoblaze_rtc_out_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write_strobe = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic [7:0] rtc_ad_out;
  logic       rtc_ad_oe;
  wire  [7:0] rtc_ad_in;
  logic       rtc_cs_n, rtc_ale, rtc_rd_n, rtc_wr_n;
  logic [7:0] rd_data;
  logic       busy, done, fmt_12h;
  logic [7:0] ad_val = 8'h00;

  assign rtc_ad_in = rtc_rd_n ? 8'h00 : ad_val;

  picoblaze_rtc_out_port dut (
    .clk          (clk),
    .reset        (reset),
    .write_strobe (write_strobe),
    .port_id      (port_id),
    .out_port     (out_port),
    .rtc_ad_out   (rtc_ad_out),
    .rtc_ad_oe    (rtc_ad_oe),
    .rtc_ad_in    (rtc_ad_in),
    .rtc_cs_n     (rtc_cs_n),
    .rtc_ale      (rtc_ale),
    .rtc_rd_n     (rtc_rd_n),
    .rtc_wr_n     (rtc_wr_n),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .fmt_12h      (fmt_12h)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    int         t0;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int ale_n, wr_n_cnt, rd_n_cnt, busy_n;
  logic [7:0] ale_addr, wr_data;
  bit both_low, oe_bad;

  task automatic clr_track();
    ale_n = 0; wr_n_cnt = 0; rd_n_cnt = 0; busy_n = 0;
    ale_addr = 8'h00; wr_data = 8'h00;
    both_low = 0; oe_bad = 0;
  endtask

  initial clr_track();

  // Monitor: accumulate pad activity, score it on each done
  always @(negedge clk) begin
    if (reset) begin
      clr_track();
    end else begin
      if (!rtc_rd_n && !rtc_wr_n) both_low = 1;
      if (!rtc_rd_n && rtc_ad_oe) oe_bad = 1;
      if (rtc_ale) begin
        ale_n++;
        ale_addr = rtc_ad_out;
      end
      if (!rtc_wr_n) begin
        wr_n_cnt++;
        wr_data = rtc_ad_out;
      end
      if (!rtc_rd_n) rd_n_cnt++;
      if (busy) busy_n++;
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.t0, 17);
          chk("ale_cycles", ale_n, 4);
          chk("ale_addr", ale_addr, e.addr);
          chk("wr_low_cycles", wr_n_cnt, e.w ? 8 : 0);
          chk("rd_low_cycles", rd_n_cnt, e.w ? 0 : 8);
          if (e.w) chk("wr_data", wr_data, e.wdata);
          chk("rd_data", rd_data, e.rd);
          chk("busy_cycles", busy_n, 16);
          chk("busy_at_done", busy, 0);
          chk("strobes_overlap", both_low, 0);
          chk("oe_during_rd", oe_bad, 0);
        end
        clr_track();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    write_strobe = 1'b1;
    port_id = p;
    out_port = d;
    tick();
    write_strobe = 1'b0;
    port_id = 8'h00;
    out_port = 8'h00;
  endtask

  task automatic cmd_op(input logic [7:0] c, input bit w,
                        input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] rd);
    exp_t x;
    x.w = w; x.addr = a; x.wdata = wd; x.rd = rd; x.t0 = cyc;
    q.push_back(x);
    wr(8'h12, c);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s: got timeout expected done", name);
    end
  endtask

  task automatic idle_for(input int n, input string name);
    int b = 0;
    for (int i = 0; i < n; i++) begin
      if (busy) b++;
      tick();
    end
    chk(name, b, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pads"},
        {rtc_ad_out, rtc_ad_oe, rtc_cs_n, rtc_ale, rtc_rd_n, rtc_wr_n},
        {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    chk({tag, "_rd_data"}, rd_data, 8'h00);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fmt"}, fmt_12h, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset("init");

    // Write op
    wr(8'h10, 8'h21);
    wr(8'h11, 8'h45);
    cmd_op(8'h01, 1, 8'h21, 8'h45, 8'h00);
    wait_done("wait_write");

    // Read op, then a write that must leave rd_data alone
    wr(8'h10, 8'h22);
    ad_val = 8'h37;
    cmd_op(8'h02, 0, 8'h22, 8'h45, 8'h37);
    wait_done("wait_read");
    cmd_op(8'h01, 1, 8'h22, 8'h45, 8'h37);
    wait_done("wait_write2");

    // Busy lockout
    wr(8'h10, 8'h30);
    cmd_op(8'h01, 1, 8'h30, 8'h45, 8'h37);
    repeat (3) tick();
    wr(8'h10, 8'hFF);
    wr(8'h12, 8'h01);
    wr(8'h13, 8'h01);
    chk("fmt_while_busy", fmt_12h, 1);
    wait_done("wait_lockout");
    idle_for(20, "no_second_op");
    ad_val = 8'h5A;
    cmd_op(8'h02, 0, 8'h30, 8'h45, 8'h5A);
    wait_done("wait_read_locked_addr");

    // Back-to-back: command in the done cycle
    cmd_op(8'h01, 1, 8'h30, 8'h45, 8'h5A);
    wait_done("wait_b2b_1");
    ad_val = 8'hC3;
    cmd_op(8'h02, 0, 8'h30, 8'h45, 8'hC3);
    wait_done("wait_b2b_2");

    // Decode: foreign ports and empty command
    wr(8'h03, 8'hAA);
    wr(8'h14, 8'hBB);
    wr(8'hFF, 8'hCC);
    wr(8'h12, 8'h00);
    idle_for(10, "decode_idle");
    chk("decode_fmt", fmt_12h, 1);
    chk("decode_rd_data", rd_data, 8'hC3);
    cmd_op(8'h03, 1, 8'h30, 8'h45, 8'hC3);
    wait_done("wait_both_bits");

    // Reset in the middle of the write strobe
    wr(8'h10, 8'h77);
    wr(8'h12, 8'h01);
    begin
      int n = 0;
      while (rtc_wr_n !== 1'b0 && n < 50) begin
        tick();
        n++;
      end
      chk("reach_wstb", rtc_wr_n, 0);
    end
    tick();
    tick();
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_for(20, "post_reset_idle");
    cmd_op(8'h01, 1, 8'h00, 8'h00, 8'h00);
    wait_done("wait_post_reset");
    repeat (3) tick();
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
